// File: rtl/ram_bist_pkg.sv
// Shared types and pattern generators for the ram16k built-in self-test.
package ram_bist_pkg;

  // Widest word the pattern generators describe; wider words read as zero-extended.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ZEROS   = 2'd0,
    ONES    = 2'd1,
    ADDR    = 2'd2,
    CHECKER = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_e;

  // Bit bit_idx of the checkerboard word used at even addresses (...0101).
  function automatic logic checker_even(int unsigned bit_idx);
    return (bit_idx % 2) == 0;
  endfunction

  // Bit bit_idx of the checkerboard word used at odd addresses (...1010).
  function automatic logic checker_odd(int unsigned bit_idx);
    return (bit_idx % 2) == 1;
  endfunction

  // Bit bit_idx of the expected word at addr. Callers build a word of any
  // width by evaluating one call per bit, so the package stays width-agnostic.
  function automatic logic expected_data(pattern_e pat, logic [MAX_W-1:0] addr,
                                         int unsigned bit_idx);
    logic b;
    b = 1'b0;
    case (pat)
      ZEROS:   b = 1'b0;
      ONES:    b = 1'b1;
      ADDR:    b = |(addr & (MAX_W'(1) << bit_idx));
      CHECKER: b = addr[0] ? checker_odd(bit_idx) : checker_even(bit_idx);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ram16k_bist_if.sv
// Single-port RAM bus between the BIST initiator and the ram16k array.
interface ram16k_bist_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport master (output mem_address, output mem_data, output mem_wren, input mem_q);
  modport slave  (input mem_address, input mem_data, input mem_wren, output mem_q);
endinterface

// File: rtl/ram_bist_checker.sv
// Read-latency pipe, compare, saturating error counter and first-failure capture.
module ram_bist_checker
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  pattern_e          pat,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_hit
);

  logic              vld_p  [READ_LATENCY];
  logic [ADDR_W-1:0] addr_p [READ_LATENCY];
  logic [DATA_W-1:0] exp_p;

  // Delay line: slot READ_LATENCY-1 lines up with the RAM's data for that address
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= in_vld;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
    addr_p[0] <= in_addr;
    for (int i = 1; i < READ_LATENCY; i++) addr_p[i] <= addr_p[i-1];
  end

  // ---- compare stage: pipe output against expected word ----
  for (genvar g = 0; g < DATA_W; g++) begin : g_exp
    assign exp_p[g] = expected_data(pat, MAX_W'(addr_p[READ_LATENCY-1]), g);
  end

  assign err_hit = vld_p[READ_LATENCY-1] && (mem_q != exp_p);

  // Mismatch counter sticks at all-ones instead of wrapping back to zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt <= '0;
    end else if (err_hit && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  // Counter still zero means this is the first mismatch of the run
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      first_err_addr <= '0;
    end else if (err_hit && (err_cnt == '0)) begin
      first_err_addr <= addr_p[READ_LATENCY-1];
    end
  end

endmodule

// File: rtl/ram16k_bist.sv
// BIST engine: writes a pattern over the whole array, reads it back, reports errors.
module ram16k_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16
) (
  input  logic              clock,
  input  logic              sclr,
  input  logic              start,
  input  logic [1:0]        pattern,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  ram16k_bist_if.master     ram
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [2:0]        DRAIN_LAST = 3'(READ_LATENCY - 1);

  state_e            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  pattern_e          pat, pat_n;
  logic [2:0]        drain_cnt, drain_n;
  logic              clr;
  logic              err_hit;
  logic [DATA_W-1:0] data_n;

  // Next state, address counter and pattern latch
  always_comb begin
    state_n = state;
    addr_n  = addr;
    pat_n   = pat;
    drain_n = drain_cnt;
    clr     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = WRITE;
          addr_n  = '0;
          pat_n   = pattern_e'(pattern);
          clr     = 1'b1;
        end
      end
      WRITE: begin
        if (addr == LAST_ADDR) begin
          addr_n  = '0;
          state_n = READ;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      READ: begin
        if (addr == LAST_ADDR) begin
          addr_n  = '0;
          drain_n = '0;
          state_n = DRAIN;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_n = DONE;
        end else begin
          drain_n = drain_cnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---- drive stage: RAM outputs are registered copies of the next state ----
  for (genvar g = 0; g < DATA_W; g++) begin : g_wdata
    assign data_n[g] = expected_data(pat_n, MAX_W'(addr_n), g);
  end

  // State register plus registered status and RAM drive
  always_ff @(posedge clock) begin
    if (sclr) begin
      state           <= IDLE;
      addr            <= '0;
      pat             <= ZEROS;
      drain_cnt       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      ram.mem_wren    <= 1'b0;
      ram.mem_address <= '0;
      ram.mem_data    <= '0;
    end else begin
      state           <= state_n;
      addr            <= addr_n;
      pat             <= pat_n;
      drain_cnt       <= drain_n;
      busy            <= (state_n == WRITE) || (state_n == READ) || (state_n == DRAIN);
      done            <= (state_n == DONE);
      ram.mem_wren    <= (state_n == WRITE);
      ram.mem_address <= addr_n;
      ram.mem_data    <= data_n;
      // The last compare resolves on the same edge that enters DONE, so fold it in.
      if (clr) begin
        pass <= 1'b0;
      end else if (state_n == DONE) begin
        pass <= (err_cnt == '0) && !err_hit;
      end
    end
  end

  ram_bist_checker #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY),
    .ERR_W        (ERR_W)
  ) u_checker (
    .clk            (clock),
    .rst            (sclr),
    .clr            (clr),
    .pat            (pat),
    .in_vld         (state == READ),
    .in_addr        (addr),
    .mem_q          (ram.mem_q),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .err_hit        (err_hit)
  );

endmodule
